// File: rtl/vector_lane_sequencer_pkg.sv
// Shared opcode/ALU encodings and sequencer state type for the vector lane sequencer.
package vector_pkg;

    localparam logic [4:0] OP_VADD = 5'b10000;
    localparam logic [4:0] OP_VSUB = 5'b10001;
    localparam logic [4:0] OP_VMUL = 5'b10010;
    localparam logic [4:0] OP_VLDR = 5'b10100;
    localparam logic [4:0] OP_VSTR = 5'b10101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALU,
        ST_MEM,
        ST_DONE
    } seq_state_t;

    function automatic logic [1:0] alu_op_of(input logic [4:0] op);
        case (op)
            OP_VSUB: return ALU_SUB;
            OP_VMUL: return ALU_MUL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/vector_lane_sequencer_if.sv
// Issue handshake plus lane datapath / memory port signals of the sequencer.
interface vector_lane_sequencer_if #(
    parameter int IDX_W = 2
);
    logic             issue_valid;
    logic [4:0]       issue_opcode;
    logic             issue_ready;
    logic [1:0]       alu_op;
    logic [IDX_W-1:0] lane_idx;
    logic             lane_alu_en;
    logic             vreg_we;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        input  issue_valid, issue_opcode, mem_ack,
        output issue_ready, alu_op, lane_idx, lane_alu_en, vreg_we,
               mem_req, mem_we, busy, done, illegal
    );

    modport slave (
        output issue_valid, issue_opcode, mem_ack,
        input  issue_ready, alu_op, lane_idx, lane_alu_en, vreg_we,
               mem_req, mem_we, busy, done, illegal
    );
endinterface

// File: rtl/vector_lane_sequencer_counter.sv
// Lane index and per-element MUL sub-cycle counter with last-element flags.
module vector_lane_counter #(
    parameter int LANES   = 4,
    parameter int IDX_W   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             lane_step,
    input  logic             mul_step,
    output logic [IDX_W-1:0] lane_idx,
    output logic             lane_last,
    output logic             mul_last
);
    localparam int MUL_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [MUL_W-1:0] mul_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx <= '0;
            mul_cnt  <= '0;
        end else if (clear) begin
            lane_idx <= '0;
            mul_cnt  <= '0;
        end else if (lane_step) begin
            lane_idx <= lane_idx + 1'b1;
            mul_cnt  <= '0;
        end else if (mul_step) begin
            mul_cnt  <= mul_cnt + 1'b1;
        end
    end

    assign lane_last = (lane_idx == IDX_W'(LANES - 1));
    assign mul_last  = (mul_cnt == MUL_W'(MUL_LAT - 1));

endmodule

// File: rtl/vector_lane_sequencer.sv
// Issues one vector instruction element by element over a shared lane ALU and memory port.
module vector_lane_sequencer
    import vector_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int IDX_W   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vector_lane_sequencer_if.master  bus
);
    seq_state_t       state, state_nxt;
    logic [4:0]       op_q;
    logic             illegal_q;
    logic             cnt_clear, lane_step, mul_step;
    logic             lane_last, mul_last, elem_last;
    logic [IDX_W-1:0] lane_idx;
    logic             issue_is_alu, issue_is_mem;

    assign issue_is_alu = (bus.issue_opcode == OP_VADD) || (bus.issue_opcode == OP_VSUB) ||
                          (bus.issue_opcode == OP_VMUL);
    assign issue_is_mem = (bus.issue_opcode == OP_VLDR) || (bus.issue_opcode == OP_VSTR);
    assign elem_last    = (op_q != OP_VMUL) || mul_last;

    vector_lane_counter #(
        .LANES   (LANES),
        .IDX_W   (IDX_W),
        .MUL_LAT (MUL_LAT)
    ) u_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .lane_step (lane_step),
        .mul_step  (mul_step),
        .lane_idx  (lane_idx),
        .lane_last (lane_last),
        .mul_last  (mul_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Illegal opcodes are accepted but only flagged; the sequencer never leaves IDLE for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            if (state == ST_IDLE && bus.issue_valid) begin
                op_q      <= bus.issue_opcode;
                illegal_q <= !(issue_is_alu || issue_is_mem);
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_clear       = 1'b0;
        lane_step       = 1'b0;
        mul_step        = 1'b0;
        bus.issue_ready = 1'b0;
        bus.alu_op      = ALU_ADD;
        bus.lane_idx    = lane_idx;
        bus.lane_alu_en = 1'b0;
        bus.vreg_we     = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = illegal_q;
        case (state)
            ST_IDLE: begin
                bus.issue_ready = 1'b1;
                if (bus.issue_valid) begin
                    cnt_clear = 1'b1;
                    if (issue_is_alu)      state_nxt = ST_ALU;
                    else if (issue_is_mem) state_nxt = ST_MEM;
                end
            end
            ST_ALU: begin
                bus.busy        = 1'b1;
                bus.lane_alu_en = 1'b1;
                bus.alu_op      = alu_op_of(op_q);
                bus.vreg_we     = elem_last;
                if (!elem_last) begin
                    mul_step = 1'b1;
                end else if (lane_last) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    lane_step = 1'b1;
                end
            end
            // Load write-enable follows the ack in the same cycle; everything else is state-decoded.
            ST_MEM: begin
                bus.busy    = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = (op_q == OP_VSTR);
                bus.vreg_we = (op_q == OP_VLDR) && bus.mem_ack;
                if (bus.mem_ack) begin
                    if (lane_last) begin
                        cnt_clear = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        lane_step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Randomized bench: expected per-cycle outputs are built from the instruction's element schedule.
module tb_vector_lane_sequencer;
    import vector_pkg::*;

    localparam int LANES   = 4;
    localparam int IDX_W   = 2;
    localparam int MUL_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vector_lane_sequencer_if #(.IDX_W(IDX_W)) bus ();

    vector_lane_sequencer #(
        .LANES   (LANES),
        .IDX_W   (IDX_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_ill = 1'b0;
    int   forced_delays[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input bit ready, input bit busy, input bit alu_en,
                              input bit we, input bit req, input bit mwe, input bit dn,
                              input bit ill, input int aop, input int idx);
        check({tag, ".issue_ready"}, 32'(bus.issue_ready), 32'(ready));
        check({tag, ".busy"},        32'(bus.busy),        32'(busy));
        check({tag, ".lane_alu_en"}, 32'(bus.lane_alu_en), 32'(alu_en));
        check({tag, ".vreg_we"},     32'(bus.vreg_we),     32'(we));
        check({tag, ".mem_req"},     32'(bus.mem_req),     32'(req));
        check({tag, ".mem_we"},      32'(bus.mem_we),      32'(mwe));
        check({tag, ".done"},        32'(bus.done),        32'(dn));
        check({tag, ".illegal"},     32'(bus.illegal),     32'(ill));
        check({tag, ".alu_op"},      32'(bus.alu_op),      32'(aop));
        check({tag, ".lane_idx"},    32'(bus.lane_idx),    32'(idx));
    endtask

    // Inputs that must be ignored while busy are randomized on every busy cycle.
    task automatic noise();
        bus.issue_valid  = 1'($urandom_range(0, 1));
        bus.issue_opcode = 5'($urandom);
    endtask

    task automatic run_alu(input int aop, input bit is_mul);
        int sub = is_mul ? MUL_LAT : 1;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < sub; k++) begin
                noise();
                bus.mem_ack = 1'($urandom_range(0, 1));
                #1 expect_out("alu", 0, 1, 1, (k == sub - 1), 0, 0, 0, 0, aop, l);
                @(negedge clk);
            end
        end
    endtask

    task automatic run_mem(input bit is_st);
        int d;
        for (int l = 0; l < LANES; l++) begin
            d = (forced_delays.size() != 0) ? forced_delays.pop_front() : int'($urandom_range(0, 2));
            for (int w = 0; w < d; w++) begin
                noise();
                bus.mem_ack = 1'b0;
                #1 expect_out("mem_wait", 0, 1, 0, 0, 1, is_st, 0, 0, 0, l);
                @(negedge clk);
            end
            noise();
            bus.mem_ack = 1'b1;
            #1 expect_out("mem_ack", 0, 1, 0, !is_st, 1, is_st, 0, 0, 0, l);
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
    endtask

    // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
    task automatic issue(input logic [4:0] opc);
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = opc;
        bus.mem_ack      = 1'($urandom_range(0, 1));
        #1 expect_out("idle", 1, 0, 0, 0, 0, 0, 0, exp_ill, 0, 0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        exp_ill         = 1'b0;
        case (opc)
            OP_VADD: run_alu(0, 1'b0);
            OP_VSUB: run_alu(1, 1'b0);
            OP_VMUL: run_alu(2, 1'b1);
            OP_VLDR: run_mem(1'b0);
            OP_VSTR: run_mem(1'b1);
            default: begin
                exp_ill = 1'b1;
                return;
            end
        endcase
        noise();
        #1 expect_out("done", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    function automatic logic [4:0] pick_illegal();
        logic [4:0] o;
        do o = 5'($urandom);
        while (o == OP_VADD || o == OP_VSUB || o == OP_VMUL || o == OP_VLDR || o == OP_VSTR);
        return o;
    endfunction

    initial begin
        logic [4:0] opc;
        bus.issue_valid  = 1'b0;
        bus.issue_opcode = '0;
        bus.mem_ack      = 1'b0;
        repeat (2) @(negedge clk);
        #1 expect_out("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(OP_VADD);
        issue(OP_VMUL);
        forced_delays = '{0, 2, 0, 1};
        issue(OP_VLDR);
        forced_delays = '{0, 0, 0, 0};
        issue(OP_VSTR);
        issue(5'b11111);
        issue(OP_VSUB);

        // Abort a load while it waits on lane 2.
        bus.issue_valid  = 1'b1;
        bus.issue_opcode = OP_VLDR;
        #1 expect_out("abort_idle", 1, 0, 0, 0, 0, 0, 0, exp_ill, 0, 0);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        exp_ill         = 1'b0;
        for (int l = 0; l < 2; l++) begin
            bus.mem_ack = 1'b1;
            #1 expect_out("abort_ack", 0, 1, 0, 1, 1, 0, 0, 0, 0, l);
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        #1 expect_out("abort_wait", 0, 1, 0, 0, 1, 0, 0, 0, 0, 2);
        rst_n = 1'b0;
        #1 expect_out("abort_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 expect_out("abort_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_VADD);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    opc = OP_VADD;
                2, 3:    opc = OP_VSUB;
                4:       opc = OP_VMUL;
                5, 6:    opc = OP_VLDR;
                7, 8:    opc = OP_VSTR;
                default: opc = pick_illegal();
            endcase
            issue(opc);
        end

        #1 expect_out("final", 1, 0, 0, 0, 0, 0, 0, exp_ill, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
